axis_rx_buffer: RTL and testbench
=================================

# axis_rx_buffer

Parametrised AXI4-Stream elastic buffer placed between the PCIe core's RX stream and the packet-decoding RX logic. It absorbs not-ready cycles on either side, with full 1-beat/cycle throughput in both directions. It carries data, tlast and an arbitrary-width tuser sideband through one inferred RAM, and it drives a registered s_axis_tready derived from an internal occupancy counter. This block replaces the fixed 128-bit, 512-deep RX buffer and adds configurable width, depth, headroom and an optional store-and-forward mode.

## Interface
- DATA_W, 128, tdata width in bits (multiple of 8).
- USER_W, 22, tuser width in bits; all bits are stored per beat, with no pass-through.
- DEPTH_LOG2, 9, RAM depth is 2**DEPTH_LOG2 beats (range 4..12).
- SLACK, 4, number of beats of headroom kept free below full when deciding s_axis_tready (range 1..DEPTH/4).
- clk  in  1  clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- s_axis_tdata  in  DATA_W  ingress data.
- s_axis_tuser  in  USER_W  ingress sideband.
- s_axis_tlast  in  1  ingress end of packet.
- s_axis_tvalid  in  1  ingress valid.
- s_axis_tready  out  1  ingress ready; a registered output.
- m_axis_tdata  out  DATA_W  egress data.
- m_axis_tuser  out  USER_W  egress sideband.
- m_axis_tlast  out  1  egress end of packet.
- m_axis_tvalid  out  1  egress valid.
- m_axis_tready  in  1  egress ready.
- level  out  DEPTH_LOG2+1  number of beats held in the block (RAM, read pipeline and output stage).

## Operation
- Write: a beat is stored when s_axis_tvalid && s_axis_tready. Each RAM word holds {tuser, tlast, tdata}. The write pointer is DEPTH_LOG2 bits and wraps modulo DEPTH.
- Read side: RAM read has 1-cycle latency and feeds a 2-entry output stage (main register plus skid register). The RAM is prefetched whenever the output stage has a free or freeing slot, so m_axis_tvalid stays high across back-to-back beats. The read pointer wraps modulo DEPTH.
- Egress handshake: a beat leaves on m_axis_tvalid && m_axis_tready. While m_axis_tvalid is high and m_axis_tready is low, tdata, tuser and tlast are held stable.
- level: +1 per ingress beat, -1 per egress beat, unchanged when both occur in the same cycle. It never exceeds DEPTH+2 and never underflows.
- Ready: s_axis_tready <= (level_next <= DEPTH - SLACK), registered every cycle. Because the register lags by one cycle, SLACK >= 1 guarantees that no accepted beat ever lands on a full RAM.
- Packet boundaries do not affect flow in the default mode; tlast is carried transparently.

## Timing
- Reset values: s_axis_tready=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, m_axis_tlast=0, level=0, and both pointers 0.
- s_axis_tready rises on the first clock edge after rst is sampled low.
- Cut-through latency: a beat accepted at edge N into an empty block presents m_axis_tvalid=1 after edge N+2.
- level reflects a transfer at edge N after edge N+1 (registered).
- Sustained throughput is 1 beat/cycle with m_axis_tready held high. With m_axis_tready toggling, no beat is dropped or duplicated.
- Reset mid-stream: all contents are discarded and the reset values are reached after the single rst edge. No partial beat is emitted.
- Simultaneous read and write at the same RAM address cannot occur: read is only issued for entries written at least one cycle earlier.

## Configuration
- AXIBUF_PKT_MODE_EN defined: store-and-forward mode.
  - A stored-packet counter increments when a beat with tlast=1 is written and decrements when a beat with tlast=1 leaves m_axis.
  - RAM prefetch into the output stage is permitted only while the counter is non-zero.
  - Deadlock escape: if level >= DEPTH - SLACK and the counter is 0, prefetch is released (cut-through) until the next tlast is written.
  - Egress latency becomes "tlast beat accepted at N -> first beat of that packet valid after N+2".
- AXIBUF_PKT_MODE_EN undefined: pure cut-through as described in Operation; the counter logic is absent.

## Test plan
- Reset and idle:
  - Hold rst 3 cycles, then release -> s_axis_tready=0 during rst and 1 one edge after release.
  - m_axis_tvalid=0 and level=0 throughout.
- Single beat:
  - Write tdata=0x0123..EF, tuser=0x2AAAAA, tlast=1 at edge N with m_axis_tready=1 -> m_axis_tvalid high after N+2 with identical fields.
  - level reads 1 after N+1 and 0 after the pop.
- Backpressure fill (DEPTH_LOG2=4, SLACK=4):
  - Stream incrementing data with m_axis_tready=0 -> s_axis_tready falls once level reaches 12; no more than 13 beats are accepted.
  - Then assert m_axis_tready -> all beats emerge in order, followed by 0..N-1 with no gaps.
- Random ready on both sides for 10,000 beats -> the output sequence equals the input sequence bit-for-bit, including tuser and tlast, and level never exceeds DEPTH+2.
- Pointer wrap: push and pop 3×DEPTH+5 beats with intermittent stalls -> no loss or duplication across the wrap boundary.
- With AXIBUF_PKT_MODE_EN defined:
  - A 5-beat packet with tlast on beat 5 -> m_axis_tvalid stays 0 until 2 cycles after beat 5 is accepted.
  - A packet longer than DEPTH-SLACK -> cut-through release occurs and the packet completes intact.

Source files
------------

// File: rtl/axis_rx_buffer.sv
// axis_rx_buffer
// ----------------------------------------------------------------------------
// AXI4-Stream elastic buffer between the PCIe core RX stream and the RX packet
// decoder. Each beat {tuser, tlast, tdata} is stored in one inferred RAM, read
// with 1-cycle latency into a 2-entry output stage (main + skid) so both sides
// sustain 1 beat/cycle. s_axis_tready is registered from the internal
// occupancy and keeps SLACK beats of headroom below DEPTH.
//
// Optional feature (compile-time macro AXIBUF_PKT_MODE_EN):
//   defined   : store-and-forward. RAM prefetch only while at least one
//               complete packet is stored, with a cut-through escape when the
//               buffer is nearly full and holds no complete packet.
//   undefined : pure cut-through.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   s_axis_*        ingress stream (tdata/tuser/tlast/tvalid in, tready out)
//   m_axis_*        egress stream (tdata/tuser/tlast/tvalid out, tready in)
//   level           beats held in RAM + read pipeline + output stage; a
//                   registered copy of the occupancy, one edge behind it
// ----------------------------------------------------------------------------
module axis_rx_buffer #(
    parameter int DATA_W     = 128,
    parameter int USER_W     = 22,
    parameter int DEPTH_LOG2 = 9,
    parameter int SLACK      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     s_axis_tdata,
    input  logic [USER_W-1:0]     s_axis_tuser,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_W-1:0]     m_axis_tdata,
    output logic [USER_W-1:0]     m_axis_tuser,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - SLACK);

    typedef struct packed {
        logic [USER_W-1:0] user;
        logic              last;
        logic [DATA_W-1:0] data;
    } beat_t;

    beat_t mem [DEPTH];

    beat_t                 wr_beat;
    beat_t                 rd_beat;
    beat_t                 main_beat;
    beat_t                 skid_beat;
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [CW-1:0]         ram_cnt;   // written but not yet read out of RAM
    logic [CW-1:0]         occ;
    logic [CW-1:0]         occ_next;
    logic                  rd_vld;    // rd_beat holds a word read last cycle
    logic                  main_vld;
    logic                  skid_vld;
    logic                  push;
    logic                  pop;
    logic                  room;
    logic                  issue;
    logic                  prefetch_ok;
    logic [1:0]            stage_cnt;

    assign wr_beat = '{user: s_axis_tuser, last: s_axis_tlast, data: s_axis_tdata};
    assign push    = s_axis_tvalid && s_axis_tready;
    assign pop     = main_vld && m_axis_tready;

    // Entries committed to the output stage, counting the read in flight.
    // A new read may start only if, after this cycle's pop, at most one of
    // the two slots is spoken for, so the arriving word always has a home.
    assign stage_cnt = 2'(main_vld) + 2'(skid_vld) + 2'(rd_vld);
    assign room      = (stage_cnt - 2'(pop)) <= 2'd1;
    // ram_cnt != 0 means the entry at rd_ptr was written on an earlier edge,
    // so a read never targets the address being written this cycle.
    assign issue     = (ram_cnt != '0) && room && prefetch_ok;

`ifdef AXIBUF_PKT_MODE_EN
    logic [CW-1:0] pkt_cnt;   // complete packets currently held
    logic          rel_q;     // cut-through escape latched until next tlast in
    logic          rel_now;

    // Nearly full with no complete packet: the source cannot finish the
    // packet without egress, so let it stream out.
    assign rel_now     = (occ >= READY_MAX) && (pkt_cnt == '0);
    assign prefetch_ok = (pkt_cnt != '0) || rel_q || rel_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt <= '0;
            rel_q   <= 1'b0;
        end else begin
            case ({push && s_axis_tlast, pop && main_beat.last})
                2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
                2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
                default: ;
            endcase
            if (push && s_axis_tlast) rel_q <= 1'b0;
            else if (rel_now)         rel_q <= 1'b1;
        end
    end
`else
    assign prefetch_ok = 1'b1;
`endif

    always_comb begin
        occ_next = occ;
        if (push && !pop)      occ_next = occ + 1'b1;
        else if (pop && !push) occ_next = occ - 1'b1;
    end

    // Storage array: no reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (push)  mem[wr_ptr] <= wr_beat;
        if (issue) rd_beat     <= mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            ram_cnt       <= '0;
            rd_vld        <= 1'b0;
            main_vld      <= 1'b0;
            skid_vld      <= 1'b0;
            main_beat     <= '0;
            skid_beat     <= '0;
            occ           <= '0;
            level         <= '0;
            s_axis_tready <= 1'b0;
        end else begin
            if (push)  wr_ptr <= wr_ptr + 1'b1;
            if (issue) rd_ptr <= rd_ptr + 1'b1;
            case ({push, issue})
                2'b10:   ram_cnt <= ram_cnt + 1'b1;
                2'b01:   ram_cnt <= ram_cnt - 1'b1;
                default: ;
            endcase
            rd_vld <= issue;

            // Output stage keeps order main -> skid -> arriving word. The
            // skid slot is only ever filled while main is valid.
            if (pop) begin
                if (skid_vld) begin
                    main_beat <= skid_beat;
                    skid_vld  <= rd_vld;
                    if (rd_vld) skid_beat <= rd_beat;
                end else begin
                    main_vld <= rd_vld;
                    if (rd_vld) main_beat <= rd_beat;
                end
            end else if (rd_vld) begin
                if (!main_vld) begin
                    main_vld  <= 1'b1;
                    main_beat <= rd_beat;
                end else begin
                    skid_vld  <= 1'b1;
                    skid_beat <= rd_beat;
                end
            end

            occ           <= occ_next;
            level         <= occ;
            s_axis_tready <= (occ_next <= READY_MAX);
        end
    end

    assign m_axis_tvalid = main_vld;
    assign m_axis_tdata  = main_beat.data;
    assign m_axis_tuser  = main_beat.user;
    assign m_axis_tlast  = main_beat.last;

endmodule

// File: tb/tb_axis_rx_buffer.sv
// Self-checking bench for axis_rx_buffer (DEPTH_LOG2=4, SLACK=4).
// A queue model tracks every accepted beat; a negedge process compares the
// DUT against it each cycle. Directed sections add literal expectations.
module tb_axis_rx_buffer;
    localparam int DATA_W     = 128;
    localparam int USER_W     = 22;
    localparam int DEPTH_LOG2 = 4;
    localparam int SLACK      = 4;
    localparam int DEPTH      = 1 << DEPTH_LOG2;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [DATA_W-1:0]   s_axis_tdata = '0;
    logic [USER_W-1:0]   s_axis_tuser = '0;
    logic                s_axis_tlast = 1'b0;
    logic                s_axis_tvalid = 1'b0;
    logic                s_axis_tready;
    logic [DATA_W-1:0]   m_axis_tdata;
    logic [USER_W-1:0]   m_axis_tuser;
    logic                m_axis_tlast;
    logic                m_axis_tvalid;
    logic                m_axis_tready = 1'b0;
    logic [DEPTH_LOG2:0] level;

    always #5 clk = ~clk;

    axis_rx_buffer #(.DATA_W(DATA_W), .USER_W(USER_W), .DEPTH_LOG2(DEPTH_LOG2), .SLACK(SLACK)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .level(level));

    typedef struct {
        logic [DATA_W-1:0] d;
        logic [USER_W-1:0] u;
        logic              l;
        int                t;   // edge index at which the beat was accepted
    } beat_t;

    beat_t q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;
    int    lvl_d = 0;
    bit    last_rst = 1'b1;
    int    pops = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model compare: outputs after edge cyc versus the queue of held beats.
    always @(negedge clk) begin
        chk("level", 160'(level), 160'(lvl_d));
        chk("s_tready", 160'(s_axis_tready), 160'(!last_rst && (q.size() <= DEPTH - SLACK)));
        if (m_axis_tvalid) begin
            if (q.size() == 0) chk("m_beat_unexpected", 160'(m_axis_tvalid), 160'(0));
            else chk("m_beat", 160'({m_axis_tuser, m_axis_tlast, m_axis_tdata}),
                     160'({q[0].u, q[0].l, q[0].d}));
        end
`ifndef AXIBUF_PKT_MODE_EN
        // Cut-through: the oldest beat is presented exactly 2 edges after entry.
        chk("m_tvalid", 160'(m_axis_tvalid), 160'(q.size() != 0 && cyc >= q[0].t + 2));
`endif
        lvl_d = rst ? 0 : q.size();
        if (rst) q.delete();
        else begin
            if (m_axis_tvalid && m_axis_tready && q.size() != 0) begin
                void'(q.pop_front());
                pops++;
            end
            if (s_axis_tvalid && s_axis_tready)
                q.push_back('{d: s_axis_tdata, u: s_axis_tuser, l: s_axis_tlast, t: cyc + 1});
        end
        last_rst = rst;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // mode 0: s_tvalid held high, m_tready untouched; 1: periodic stalls; 2: random.
    task automatic stream(input int n, input int mode, input bit inc, input int base, input int limit);
        int sent = 0;
        int k = 0;
        bit need = 1'b1;
        bit acc;
        logic [DATA_W-1:0] d = '0;
        logic [USER_W-1:0] u = '0;
        logic l = 1'b0;
        while (sent < n && k < limit) begin
            if (need) begin
                if (inc) begin
                    d = DATA_W'(base + sent);
                    u = USER_W'(base + sent);
                    l = 1'b0;
                end else begin
                    d = {$urandom(), $urandom(), $urandom(), $urandom()};
                    u = USER_W'($urandom());
                    l = ($urandom_range(0, 3) == 0);
                end
                if (sent == n - 1) l = 1'b1;
                need = 1'b0;
            end
            case (mode)
                1: begin
                    s_axis_tvalid = (k % 7 != 3);
                    m_axis_tready = (k % 5 != 0);
                end
                2: begin
                    s_axis_tvalid = ($urandom_range(0, 9) < 7);
                    m_axis_tready = ($urandom_range(0, 9) < 6);
                end
                default: s_axis_tvalid = 1'b1;
            endcase
            s_axis_tdata = d;
            s_axis_tuser = u;
            s_axis_tlast = l;
            acc = s_axis_tvalid && s_axis_tready;
            tick;
            if (acc) begin
                sent++;
                need = 1'b1;
            end
            k++;
        end
        s_axis_tvalid = 1'b0;
        chk("stream_sent", 160'(sent), 160'(n));
    endtask

    task automatic drain(input bit rnd, input int limit);
        int k = 0;
        while ((q.size() != 0 || m_axis_tvalid) && k < limit) begin
            m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick;
            k++;
        end
        m_axis_tready = 1'b1;
        chk("drain_empty", 160'(q.size()), 160'(0));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DATA_W-1:0] sb_data;
        int p0;
        int acc_cnt;
        bit acc;

        // Reset and idle
        rst = 1'b1;
        repeat (3) begin
            tick;
            @(negedge clk);
            chk("rst_ready", 160'(s_axis_tready), 160'(0));
            chk("rst_valid", 160'(m_axis_tvalid), 160'(0));
            chk("rst_level", 160'(level), 160'(0));
        end
        tick;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_before_release", 160'(s_axis_tready), 160'(0));
        tick;
        @(negedge clk);
        chk("ready_after_release", 160'(s_axis_tready), 160'(1));
        chk("idle_level", 160'(level), 160'(0));

        // Single beat, accepted at edge N
        tick;
        sb_data = 128'h0123456789ABCDEF0123456789ABCDEF;
        m_axis_tready = 1'b1;
        s_axis_tdata  = sb_data;
        s_axis_tuser  = 22'h2AAAAA;
        s_axis_tlast  = 1'b1;
        s_axis_tvalid = 1'b1;
        tick;                                   // edge N
        s_axis_tvalid = 1'b0;
        tick;                                   // edge N+1
        @(negedge clk);
        chk("sb_level_n1", 160'(level), 160'(1));
        chk("sb_valid_n1", 160'(m_axis_tvalid), 160'(0));
        tick;                                   // edge N+2
        @(negedge clk);
        chk("sb_valid_n2", 160'(m_axis_tvalid), 160'(1));
        chk("sb_tdata", 160'(m_axis_tdata), 160'(sb_data));
        chk("sb_tuser", 160'(m_axis_tuser), 160'(22'h2AAAAA));
        chk("sb_tlast", 160'(m_axis_tlast), 160'(1));
        tick;                                   // pop
        @(negedge clk);
        chk("sb_valid_popped", 160'(m_axis_tvalid), 160'(0));
        tick;
        @(negedge clk);
        chk("sb_level_popped", 160'(level), 160'(0));

        // Backpressure fill
        tick;
        m_axis_tready = 1'b0;
        acc_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = DATA_W'(acc_cnt);
            s_axis_tuser  = USER_W'(acc_cnt);
            s_axis_tlast  = 1'b0;
            acc = s_axis_tready;
            tick;
            if (acc) acc_cnt++;
        end
        s_axis_tvalid = 1'b0;
        tick;
        tick;
        @(negedge clk);
        chk("fill_accepted", 160'(acc_cnt), 160'(13));
        chk("fill_level", 160'(level), 160'(13));
        chk("fill_ready", 160'(s_axis_tready), 160'(0));
        chk("fill_valid", 160'(m_axis_tvalid), 160'(1));
        chk("fill_head", 160'(m_axis_tdata), 160'(0));
        tick;
        m_axis_tready = 1'b1;
        stream(10, 0, 1'b1, 13, 500);
        drain(1'b0, 500);

        // Pointer wrap with periodic stalls: 3*DEPTH+5 beats
        p0 = pops;
        stream(3 * DEPTH + 5, 1, 1'b1, 1000, 2000);
        drain(1'b0, 500);
        chk("wrap_pops", 160'(pops - p0), 160'(3 * DEPTH + 5));

        // Reset mid-stream
        m_axis_tready = 1'b0;
        stream(6, 0, 1'b1, 200, 50);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_valid", 160'(m_axis_tvalid), 160'(0));
        chk("mrst_tdata", 160'(m_axis_tdata), 160'(0));
        chk("mrst_level", 160'(level), 160'(0));
        chk("mrst_ready", 160'(s_axis_tready), 160'(0));
        tick;
        @(negedge clk);
        chk("mrst_ready_back", 160'(s_axis_tready), 160'(1));
        tick;
        m_axis_tready = 1'b1;

`ifdef AXIBUF_PKT_MODE_EN
        // 5-beat packet: nothing leaves until 2 edges after the tlast beat
        for (int i = 0; i < 5; i++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = DATA_W'(300 + i);
            s_axis_tuser  = USER_W'(i);
            s_axis_tlast  = (i == 4);
            @(negedge clk);
            chk("pkt_hold", 160'(m_axis_tvalid), 160'(0));
            tick;
        end
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        chk("pkt_hold_n", 160'(m_axis_tvalid), 160'(0));
        tick;
        @(negedge clk);
        chk("pkt_hold_n1", 160'(m_axis_tvalid), 160'(0));
        tick;
        @(negedge clk);
        chk("pkt_valid_n2", 160'(m_axis_tvalid), 160'(1));
        chk("pkt_first", 160'(m_axis_tdata), 160'(300));
        tick;
        drain(1'b0, 200);

        // Packet longer than DEPTH-SLACK forces the cut-through escape
        p0 = pops;
        stream(20, 0, 1'b1, 400, 500);
        drain(1'b0, 500);
        chk("long_pkt_pops", 160'(pops - p0), 160'(20));
`endif

        // Random ready on both sides
        p0 = pops;
        stream(10000, 2, 1'b0, 0, 40000);
        drain(1'b1, 2000);
        chk("random_pops", 160'(pops - p0), 160'(10000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
